// File: rtl/result_argmax_if.sv
// Result-argmax handshake bundle: packed score lanes in, winning class/score out.
interface result_argmax_if #(
  parameter int unsigned NUM_CLASS = 10,
  parameter int unsigned DW        = 32
);
  logic [NUM_CLASS*DW-1:0] din_i;
  logic                    wr_en_i;
  logic                    ready_i;
  logic [3:0]              class_o;
  logic [DW-1:0]           score_o;
  logic                    valid_o;
  logic                    busy_o;
  logic                    drop_o;

  modport master (
    output din_i, wr_en_i, ready_i,
    input  class_o, score_o, valid_o, busy_o, drop_o
  );

  modport slave (
    input  din_i, wr_en_i, ready_i,
    output class_o, score_o, valid_o, busy_o, drop_o
  );
endinterface

// File: rtl/result_argmax.sv
// Sequential signed argmax over NUM_CLASS score lanes, one compare per cycle,
// with a valid/ready result handshake and a sticky dropped-strobe flag.
module result_argmax #(
  parameter int unsigned NUM_CLASS = 10,
  parameter int unsigned DW        = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  result_argmax_if.slave   bus
);
  localparam int unsigned IW = 4;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e               state_q;
  logic signed [DW-1:0] buf_q [NUM_CLASS];
  logic signed [DW-1:0] best_q, best_d;
  logic [IW-1:0]        best_idx_q, best_idx_d;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        class_q;
  logic [DW-1:0]        score_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 drop_q;

  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    best_d     = best_q;
    best_idx_d = best_idx_q;
    if (buf_q[idx_q] > best_q) begin
      best_d     = buf_q[idx_q];
      best_idx_d = idx_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      best_q     <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      class_q    <= '0;
      score_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.wr_en_i) begin
            for (int unsigned k = 0; k < NUM_CLASS; k++) begin
              buf_q[k] <= bus.din_i[DW*k +: DW];
            end
            best_q     <= bus.din_i[DW-1:0];
            best_idx_q <= '0;
            idx_q      <= IW'(1);
            busy_q     <= 1'b1;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (bus.wr_en_i) drop_q <= 1'b1;
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          idx_q      <= idx_q + IW'(1);
          if (idx_q == IW'(NUM_CLASS-1)) begin
            class_q <= best_idx_d;
            score_q <= best_d;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.wr_en_i) drop_q <= 1'b1;
          if (bus.ready_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.class_o = class_q;
  assign bus.score_o = score_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy_q;
  assign bus.drop_o  = drop_q;
endmodule
